ascon_session_ctrl: RTL and testbench
=====================================

ASCON_SESSION_CTRL -- requirements
Module: ascon_session_ctrl

Interface
REQ-001 SHALL have parameter NB_BLOCKS, default 23, the number of 64-bit cipher blocks per ECG frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum number of cycles allowed between cipher strobes while running.
REQ-003 SHALL have ports:
- clock_i  in  1  single clock for the block.
- reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_nonce_i  in  1  loads nonce_init_i into the nonce register while IDLE.
REQ-005 SHALL have port nonce_init_i  in  128  initial nonce value.
REQ-006 SHALL have port req_i  in  1  host request for one encryption session.
REQ-007 SHALL have port ack_i  in  1  host acknowledge of done_o or err_o.
REQ-008 SHALL have port cipher_en_i  in  1  one-cycle strobe from the ASCON sequencer: a cipher block or the tag is valid.
REQ-009 SHALL have port cipher_i  in  64  cipher block from the ASCON core.
REQ-010 SHALL have port tag_i  in  128  tag from the ASCON core.
REQ-011 SHALL have port start_o  out  1  one-cycle start pulse to the ASCON sequencer.
REQ-012 SHALL have port nonce_o  out  128  nonce for the current session.
REQ-013 SHALL have port frame_o  out  64*NB_BLOCKS  collected cipher frame, block 0 in the MSBs.
REQ-014 SHALL have port tag_o  out  128  captured tag.
REQ-015 SHALL have port busy_o  out  1  high when the state is not IDLE.
REQ-016 SHALL have port done_o  out  1  high while in DONE.
REQ-017 SHALL have port err_o  out  1  high while in ERROR.
REQ-018 SHALL have port session_cnt_o  out  16  completed sessions, wraps at 2^16.

Function
REQ-019 SHALL implement the states IDLE, START, RUN, DONE and ERROR.
REQ-020 IDLE: load_nonce_i=1 SHALL load the nonce and stay IDLE; otherwise req_i=1 SHALL go to START; load_nonce_i has priority over req_i in the same cycle.
REQ-021 START SHALL last exactly one cycle with start_o=1, clear frame_o, tag_o, the block counter and the watchdog, then go to RUN.
REQ-022 RUN, cipher_en_i with block count k<NB_BLOCKS: SHALL write cipher_i into frame_o bits [64*NB_BLOCKS-1-64k -: 64] and increment k.
REQ-023 RUN, cipher_en_i with k==NB_BLOCKS: SHALL capture tag_i into tag_o and go to DONE next cycle.
REQ-024 On entry to DONE, nonce_o SHALL increment by 1 mod 2^128 and session_cnt_o SHALL increment by 1.
REQ-025 The DONE entry update (REQ-024) SHALL take effect on the same edge as the tag capture.
REQ-026 DONE SHALL hold frame_o and tag_o stable and stay until ack_i=1, then go to IDLE.
REQ-027 Watchdog in RUN: count cycles since START or the last cipher_en_i.
REQ-028 When the watchdog reaches TIMEOUT_CYCLES-1 without a strobe, the block SHALL go to ERROR.
REQ-029 A strobe in the same cycle as the timeout SHALL win: the block is captured and it stays in RUN.
REQ-030 ERROR SHALL NOT increment nonce_o or session_cnt_o, and SHALL keep partial frame_o contents.
REQ-031 ERROR SHALL stay until ack_i=1, then go to IDLE.
REQ-032 cipher_en_i in IDLE, START, DONE or ERROR SHALL be ignored.
REQ-033 ack_i outside DONE and ERROR SHALL be ignored.
REQ-034 req_i held high SHALL NOT re-trigger a session until the state has passed through IDLE.
REQ-035 All outputs SHALL be registered, except busy_o, done_o and err_o, which are decoded from the state register.

Reset
REQ-036 reset_i=1 SHALL asynchronously force IDLE and clear every register: start_o, nonce_o, frame_o, tag_o, session_cnt_o, the block counter and the watchdog all =0.
REQ-037 busy_o, done_o and err_o SHALL be 0 during reset.
REQ-038 Reset during RUN SHALL abandon the session with no nonce increment.

Structure
REQ-039 The shared package ascon_pkg SHALL hold the state enum, BLOCK_W=64, TAG_W=128 and NONCE_W=128.
REQ-040 The watchdog SHALL be the sub-module session_watchdog, with clear, enable and a timeout pulse, parameterised by TIMEOUT_CYCLES.
REQ-041 The block counter SHALL be $clog2(NB_BLOCKS+1) bits wide.

Verification
REQ-042 Nominal: load nonce 0x0...01, then req, then 24 strobes with cipher_i=k and tag_i=0xAA..AA -> start_o pulses once; frame_o block k=k; tag_o=0xAA..AA; done_o=1; nonce_o=0x0...02; session_cnt_o=1.
REQ-043 Timeout, TIMEOUT_CYCLES=16: req, then 5 strobes, then silence -> err_o=1 exactly 15 cycles after the last strobe; nonce_o unchanged; ack_i returns to IDLE.
REQ-044 Priority: load_nonce_i and req_i in the same cycle -> nonce loaded, START one cycle later; stray cipher_en_i in IDLE/DONE -> frame_o unchanged.
REQ-045 Reset mid-RUN after 10 blocks -> all outputs 0, IDLE; the next session starts from the originally loaded nonce, not incremented.
REQ-046 Wrap: nonce 0xFF..FF, complete session -> nonce_o=0; session_cnt_o preset path 0xFFFF -> 0.
REQ-047 req_i held high across DONE plus ack -> exactly one new start_o after IDLE, never two back-to-back.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and widths for the ASCON session control slice.
package ascon_pkg;

    localparam int BLOCK_W = 64;
    localparam int TAG_W   = 128;
    localparam int NONCE_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/session_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module session_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // The edge ending this cycle is the one that brings the count to TIMEOUT_CYCLES-1.
    assign timeout = enable && (count_q == LAST);

endmodule

// File: rtl/ascon_session_ctrl.sv
// Session controller around the ASCON sequencer: nonce management, frame and
// tag collection, watchdog supervision and completed-session counting.
module ascon_session_ctrl
    import ascon_pkg::*;
#(
    parameter int NB_BLOCKS      = 23,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        load_nonce_i,
    input  logic [NONCE_W-1:0]          nonce_init_i,
    input  logic                        req_i,
    input  logic                        ack_i,
    input  logic                        cipher_en_i,
    input  logic [BLOCK_W-1:0]          cipher_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        start_o,
    output logic [NONCE_W-1:0]          nonce_o,
    output logic [BLOCK_W*NB_BLOCKS-1:0] frame_o,
    output logic [TAG_W-1:0]            tag_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [15:0]                 session_cnt_o
);

    localparam int FRAME_W = BLOCK_W * NB_BLOCKS;
    localparam int BCNT_W  = $clog2(NB_BLOCKS + 1);

    state_t            state_q;
    state_t            state_d;
    logic [BCNT_W-1:0] blk_cnt_q;
    logic              strobe;
    logic              last_blk;
    logic              done_entry;
    logic              timeout;
    logic [15:0]       session_cnt_d;

    assign strobe     = (state_q == ST_RUN) && cipher_en_i;
    assign last_blk   = (blk_cnt_q == BCNT_W'(NB_BLOCKS));
    assign done_entry = strobe && last_blk;

    assign session_cnt_d = done_entry ? session_cnt_o + 16'd1 : session_cnt_o;

    session_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear   ((state_q == ST_START) || strobe),
        .enable  (state_q == ST_RUN),
        .timeout (timeout)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe always beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!load_nonce_i && req_i) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (done_entry) begin
                    state_d = ST_DONE;
                end else if (!strobe && timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE:  if (ack_i) state_d = ST_IDLE;
            ST_ERROR: if (ack_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
        err_o  = (state_q == ST_ERROR);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            start_o       <= 1'b0;
            nonce_o       <= '0;
            frame_o       <= '0;
            tag_o         <= '0;
            blk_cnt_q     <= '0;
            session_cnt_o <= '0;
        end else begin
            start_o       <= (state_d == ST_START);
            session_cnt_o <= session_cnt_d;
            if ((state_q == ST_IDLE) && load_nonce_i) begin
                nonce_o <= nonce_init_i;
            end
            if (state_q == ST_START) begin
                frame_o   <= '0;
                tag_o     <= '0;
                blk_cnt_q <= '0;
            end
            if (strobe) begin
                if (!last_blk) begin
                    for (int b = 0; b < NB_BLOCKS; b++) begin
                        if (blk_cnt_q == BCNT_W'(b)) begin
                            frame_o[FRAME_W-1-BLOCK_W*b -: BLOCK_W] <= cipher_i;
                        end
                    end
                    blk_cnt_q <= blk_cnt_q + BCNT_W'(1);
                end else begin
                    tag_o   <= tag_i;
                    nonce_o <= nonce_o + 128'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascon_session_ctrl.sv
// Directed bench for ascon_session_ctrl with a short watchdog.
module tb_ascon_session_ctrl;

    localparam int NB  = 23;
    localparam int TMO = 16;

    logic              clock_i;
    logic              reset_i;
    logic              load_nonce_i;
    logic [127:0]      nonce_init_i;
    logic              req_i;
    logic              ack_i;
    logic              cipher_en_i;
    logic [63:0]       cipher_i;
    logic [127:0]      tag_i;
    logic              start_o;
    logic [127:0]      nonce_o;
    logic [64*NB-1:0]  frame_o;
    logic [127:0]      tag_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       session_cnt_o;

    int total = 0;
    int bad   = 0;

    ascon_session_ctrl #(
        .NB_BLOCKS(NB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .load_nonce_i  (load_nonce_i),
        .nonce_init_i  (nonce_init_i),
        .req_i         (req_i),
        .ack_i         (ack_i),
        .cipher_en_i   (cipher_en_i),
        .cipher_i      (cipher_i),
        .tag_i         (tag_i),
        .start_o       (start_o),
        .nonce_o       (nonce_o),
        .frame_o       (frame_o),
        .tag_o         (tag_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .session_cnt_o (session_cnt_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [63:0] blk(input int k);
        return frame_o[64*NB-1-64*k -: 64];
    endfunction

    task automatic strobe(input logic [63:0] c);
        cipher_en_i = 1'b1;
        cipher_i    = c;
        tick;
        cipher_en_i = 1'b0;
    endtask

    task automatic load(input logic [127:0] n);
        load_nonce_i = 1'b1;
        nonce_init_i = n;
        tick;
        load_nonce_i = 1'b0;
    endtask

    task automatic full_session(input logic [127:0] t);
        req_i = 1'b1;
        tick;
        req_i = 1'b0;
        tick;
        tag_i = t;
        for (int k = 0; k <= NB; k++) strobe(64'(k));
    endtask

    initial begin
        reset_i      = 1'b1;
        load_nonce_i = 1'b0;
        nonce_init_i = '0;
        req_i        = 1'b0;
        ack_i        = 1'b0;
        cipher_en_i  = 1'b0;
        cipher_i     = '0;
        tag_i        = '0;
        tick;
        tick;
        chk("rst_busy",  128'(busy_o), 128'd0);
        chk("rst_done",  128'(done_o), 128'd0);
        chk("rst_err",   128'(err_o), 128'd0);
        chk("rst_start", 128'(start_o), 128'd0);
        chk("rst_nonce", nonce_o, 128'd0);
        chk("rst_scnt",  128'(session_cnt_o), 128'd0);
        reset_i = 1'b0;
        tick;

        // Nominal session
        load(128'd1);
        chk("nom_load", nonce_o, 128'd1);
        req_i = 1'b1;
        tick;
        chk("nom_start_hi", 128'(start_o), 128'd1);
        chk("nom_busy", 128'(busy_o), 128'd1);
        req_i = 1'b0;
        tick;
        chk("nom_start_lo", 128'(start_o), 128'd0);
        tag_i = {16{8'hAA}};
        for (int k = 0; k <= NB; k++) strobe(64'(k));
        chk("nom_done", 128'(done_o), 128'd1);
        chk("nom_tag", tag_o, {16{8'hAA}});
        chk("nom_nonce", nonce_o, 128'd2);
        chk("nom_scnt", 128'(session_cnt_o), 128'd1);
        chk("nom_start_once", 128'(start_o), 128'd0);
        for (int k = 0; k < NB; k++) chk($sformatf("nom_blk%0d", k), 128'(blk(k)), 128'(k));
        strobe({16{4'hF}});
        chk("done_stray_blk0", 128'(blk(0)), 128'd0);
        chk("done_stray_blk22", 128'(blk(22)), 128'd22);
        chk("done_hold", 128'(done_o), 128'd1);
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("nom_ack_idle", 128'(busy_o), 128'd0);
        strobe({16{4'hF}});
        chk("idle_stray_blk0", 128'(blk(0)), 128'd0);
        chk("idle_stray_busy", 128'(busy_o), 128'd0);

        // Priority: load and req together
        load_nonce_i = 1'b1;
        req_i        = 1'b1;
        nonce_init_i = 128'h10;
        tick;
        load_nonce_i = 1'b0;
        chk("pri_nonce", nonce_o, 128'h10);
        chk("pri_idle", 128'(busy_o), 128'd0);
        chk("pri_nostart", 128'(start_o), 128'd0);
        tick;
        chk("pri_start", 128'(start_o), 128'd1);
        req_i = 1'b0;
        tick;
        chk("clr_tag", tag_o, 128'd0);
        chk("clr_blk22", 128'(blk(22)), 128'd0);

        // Timeout, with one strobe landing on the timeout cycle
        for (int k = 0; k < 5; k++) strobe(64'(100 + k));
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        for (int i = 0; i < 13; i++) tick;
        chk("to_pre_err", 128'(err_o), 128'd0);
        strobe(64'd105);
        chk("to_win_err", 128'(err_o), 128'd0);
        chk("to_win_busy", 128'(busy_o), 128'd1);
        chk("to_win_blk5", 128'(blk(5)), 128'd105);
        for (int i = 0; i < 14; i++) tick;
        chk("to_14_err", 128'(err_o), 128'd0);
        tick;
        chk("to_15_err", 128'(err_o), 128'd1);
        chk("to_done", 128'(done_o), 128'd0);
        chk("to_nonce", nonce_o, 128'h10);
        chk("to_scnt", 128'(session_cnt_o), 128'd1);
        chk("to_blk0", 128'(blk(0)), 128'd100);
        chk("to_blk4", 128'(blk(4)), 128'd104);
        tick;
        chk("to_hold", 128'(err_o), 128'd1);
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("to_ack_idle", 128'(busy_o), 128'd0);
        chk("to_ack_err", 128'(err_o), 128'd0);

        // Reset in the middle of a session
        load(128'h55);
        req_i = 1'b1;
        tick;
        req_i = 1'b0;
        tick;
        for (int k = 0; k < 10; k++) strobe(64'(k + 1));
        chk("mid_blk9", 128'(blk(9)), 128'd10);
        reset_i = 1'b1;
        #2;
        chk("mr_busy", 128'(busy_o), 128'd0);
        chk("mr_nonce", nonce_o, 128'd0);
        chk("mr_blk0", 128'(blk(0)), 128'd0);
        chk("mr_tag", tag_o, 128'd0);
        chk("mr_scnt", 128'(session_cnt_o), 128'd0);
        chk("mr_start", 128'(start_o), 128'd0);
        tick;
        reset_i = 1'b0;
        tick;
        load(128'h55);
        full_session(128'h1234);
        chk("mr_next_nonce", nonce_o, 128'h56);
        chk("mr_next_scnt", 128'(session_cnt_o), 128'd1);
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;

        // Wrap of nonce and session counter
        load({128{1'b1}});
        force dut.session_cnt_d = 16'hFFFF;
        tick;
        release dut.session_cnt_d;
        chk("wrap_preset", 128'(session_cnt_o), 128'hFFFF);
        full_session(128'h77);
        chk("wrap_done", 128'(done_o), 128'd1);
        chk("wrap_nonce", nonce_o, 128'd0);
        chk("wrap_scnt", 128'(session_cnt_o), 128'd0);

        // req held high across DONE and ack
        req_i = 1'b1;
        tick;
        chk("hold_done_nostart", 128'(start_o), 128'd0);
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("hold_idle_nostart", 128'(start_o), 128'd0);
        chk("hold_idle", 128'(busy_o), 128'd0);
        tick;
        chk("hold_start", 128'(start_o), 128'd1);
        tick;
        chk("hold_start_lo1", 128'(start_o), 128'd0);
        tick;
        chk("hold_start_lo2", 128'(start_o), 128'd0);
        req_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
